fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the opcode decoder.
- Owns the PC and drives a single-outstanding request/grant/response instruction-memory port.
- Presents {valid, pc, instr, opcode} to decode.
- Honours stall from the hazard unit and PC redirect on taken branch.

Parameters:
- PC_W, 8, PC width in bits; word-addressed, one instruction per address.
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- o_imem_req  out  1  request valid; address on o_imem_addr.
- o_imem_addr  out  PC_W  fetch address.
- i_imem_gnt  in  1  request accepted this cycle (req && gnt = handshake).
- i_imem_rvalid  in  1  response data valid; at least 1 cycle after grant.
- i_imem_rdata  in  INSTR_W  instruction returned.
- i_stall  in  1  decode cannot consume; IF/ID register holds.
- i_redirect  in  1  taken branch / flush; overrides stall.
- i_redirect_pc  in  PC_W  redirect target.
- o_valid  out  1  IF/ID holds a real instruction; decode must qualify RegWrite/MemWrite/branch with it.
- o_pc  out  PC_W  PC of the held instruction.
- o_instr  out  INSTR_W  held instruction.
- o_opcode  out  4  o_instr[INSTR_W-1 -: 4], feeds decoder i_opcode.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; state=S_REQ; kill=0; skid empty.
  - o_valid=0, o_pc=0, o_instr=0.
  - Performance counters (if compiled in) = 0.
- Reset mid-transaction abandons any outstanding response. The memory side is reset by the same i_reset.
- States:
  - S_REQ: o_imem_req=1, o_imem_addr=pc. On gnt: req_pc<=pc, pc<=pc+1 (wraps mod 2^PC_W), go S_WAIT.
  - S_WAIT: o_imem_req=0. On rvalid:
    - kill=1: drop the data, clear kill, go S_REQ.
    - IF/ID free (o_valid=0 or i_stall=0): load IF/ID with {1, req_pc, rdata}, go S_REQ.
    - Otherwise: write skid buffer, go S_HOLD.
  - S_HOLD: o_imem_req=0. When i_stall=0: skid moves into IF/ID, skid empties, go S_REQ.
- IF/ID consumption: when i_stall=0 and no new load, o_valid<=0 (bubble). When i_stall=1, all IF/ID outputs hold.
- Redirect (priority: reset > redirect > stall > normal):
  - pc<=i_redirect_pc; o_valid<=0; skid cleared.
  - In S_WAIT, or in S_REQ with gnt in the same cycle: kill<=1, state S_WAIT.
  - In S_HOLD or S_REQ without gnt: state S_REQ.
  - rvalid arriving in the redirect cycle is dropped.
- Redirect latency: redirect at cycle N, request for target at N+1. With gnt at N+1 and rvalid at N+2, o_valid=1 at N+3.
- Throughput with a 1-cycle memory: one instruction every 2 cycles (single outstanding request).
- At most one request outstanding. A response with no outstanding request is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds two 16-bit saturating outputs, cleared on reset.
  - o_fetch_cnt increments on each IF/ID load of a valid instruction.
  - o_bubble_cnt increments each cycle with o_valid=0 and i_stall=0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W and PC_W defaults.
  - Opcode field slice constants (OPC_MSB=15, OPC_LSB=12).
  - Opcode group encodings LDA=2'b00, STA=2'b01, IMM=2'b10, BAF=2'b11.
  - fetch state enum {S_REQ, S_WAIT, S_HOLD}.
- One sub-module: fetch_skid_buf (1-entry {pc, instr} buffer with full flag, load/drain/clear).

Test Plan:
- Reset release, memory returns rdata=16'h1234 one cycle after each grant.
  - First request addr 0.
  - o_valid=1, o_pc=0, o_instr=16'h1234, o_opcode=4'h1 two cycles after first grant.
  - Next request addr 1.
- i_stall=1 for 4 cycles while a response arrives.
  - Response goes to skid; IF/ID held; no new request.
  - Stall release: skid instruction appears next cycle; request resumes at next PC.
- i_redirect=1, target 8'h40, while in S_WAIT.
  - Old response dropped (never valid).
  - Next request addr 8'h40.
  - o_valid=0 until the 8'h40 instruction arrives.
- i_redirect and i_stall both 1 with IF/ID valid.
  - o_valid=0 next cycle; skid empty; request addr = target.
- PC=8'hFF granted.
  - Next request addr 8'h00; o_pc of the fetched instruction = 8'hFF.
- Assert i_reset while in S_WAIT.
  - Outputs go to 0 immediately (before next edge).
  - After release, first request addr RESET_PC.
  - With FETCH_PERF_CNT_EN: counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Desc     : Shared CPU front-end types and constants (widths, opcode field,
//            opcode groups, fetch FSM encoding).
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int DEFAULT_PC_W    = 8;
    localparam int DEFAULT_INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    // Opcode group lives in the top two opcode bits
    localparam logic [1:0] LDA = 2'b00;
    localparam logic [1:0] STA = 2'b01;
    localparam logic [1:0] IMM = 2'b10;
    localparam logic [1:0] BAF = 2'b11;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Desc     : One-entry {pc, instr} holding buffer with full flag; clear wins
//            over load, load wins over drain.
// Revision : 1.0
// ============================================================================
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int PC_W    = DEFAULT_PC_W,
    parameter int INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_drain,
    input  logic               i_clear,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_full,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr
);

    logic               r_full;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_full  <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Desc     : Instruction fetch with single-outstanding imem port and IF/ID
//            register. Define FETCH_PERF_CNT_EN to add fetch/bubble counters.
// Revision : 1.0
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter int              INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic               o_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic [3:0]         o_opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        o_fetch_cnt,
    output logic [15:0]        o_bubble_cnt
`endif
);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_req_pc;
    logic               r_kill;
    logic               r_valid;
    logic [PC_W-1:0]    r_out_pc;
    logic [INSTR_W-1:0] r_instr;

    logic               w_rsp;
    logic               w_ifid_free;
    logic               w_load;
    logic               w_skid_load;
    logic               w_drain;
    logic               w_skid_full;
    logic [PC_W-1:0]    w_skid_pc;
    logic [INSTR_W-1:0] w_skid_instr;

    // A live response is one for the request we still care about
    assign w_rsp       = (r_state == S_WAIT) && i_imem_rvalid && !r_kill;
    assign w_ifid_free = !r_valid || !i_stall;
    assign w_load      = !i_redirect && w_rsp && w_ifid_free;
    assign w_skid_load = !i_redirect && w_rsp && !w_ifid_free;
    assign w_drain     = !i_redirect && (r_state == S_HOLD) && w_skid_full && !i_stall;

    fetch_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_skid_load),
        .i_drain (w_drain),
        .i_clear (i_redirect),
        .i_pc    (r_req_pc),
        .i_instr (i_imem_rdata),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_kill   <= 1'b0;
            r_valid  <= 1'b0;
            r_out_pc <= '0;
            r_instr  <= '0;
        end else if (i_redirect) begin
            r_pc    <= i_redirect_pc;
            r_valid <= 1'b0;
            case (r_state)
                S_REQ: begin
                    if (i_imem_gnt) begin
                        r_req_pc <= r_pc;
                        r_kill   <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response landing now is dropped and nothing stays outstanding
                    r_kill  <= !i_imem_rvalid;
                    r_state <= i_imem_rvalid ? S_REQ : S_WAIT;
                end
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_imem_gnt) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + PC_W'(1);
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        r_kill  <= 1'b0;
                        r_state <= (r_kill || w_ifid_free) ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase

            if (w_load) begin
                r_valid  <= 1'b1;
                r_out_pc <= r_req_pc;
                r_instr  <= i_imem_rdata;
            end else if (w_drain) begin
                r_valid  <= 1'b1;
                r_out_pc <= w_skid_pc;
                r_instr  <= w_skid_instr;
            end else if (!i_stall) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_imem_req  = (r_state == S_REQ);
    assign o_imem_addr = r_pc;
    assign o_valid     = r_valid;
    assign o_pc        = r_out_pc;
    assign o_instr     = r_instr;
    assign o_opcode    = r_instr[INSTR_W-1 -: OPC_W];

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if ((w_load || w_drain) && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (!r_valid && !i_stall && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign o_fetch_cnt  = r_fetch_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Desc     : Self-checking bench for fetch_stage: scoreboard of granted fetches
//            plus a redirect vector table. Honours FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [15:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect;
    logic [7:0]  i_redirect_pc;
    logic        o_valid;
    logic [7:0]  o_pc;
    logic [15:0] o_instr;
    logic [3:0]  o_opcode;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] o_fetch_cnt;
    logic [15:0] o_bubble_cnt;
`endif

    fetch_stage #(
        .PC_W     (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_opcode      (o_opcode)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_fetch_cnt   (o_fetch_cnt),
        .o_bubble_cnt  (o_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } sb_t;

    typedef struct {
        logic [7:0]  tgt;
        logic [15:0] exp_instr;
        logic [7:0]  exp_next;
    } vec_t;

    sb_t   sbq[$];
    vec_t  vecs[4];
    int    checks = 0;
    int    errors = 0;

    logic        fixed_mode;
    logic        gnt_en;
    int          mem_lat;
    logic        mem_pending;
    int          mem_cnt;
    logic [15:0] mem_rd;
    logic        last_valid;
    logic        last_stall;

    function automatic logic [15:0] mem_data(input logic [7:0] a);
        if (fixed_mode) return 16'h1234;
        return {~a[3:0], 4'hC, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observe outputs at the falling edge; a new instruction is popped against the scoreboard
    task automatic sample();
        sb_t e;
        @(negedge clk);
        if (!i_reset && o_valid && (!last_valid || !last_stall)) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_pc", 32'(o_pc), 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                check("sb_pc", 32'(o_pc), 32'(e.pc));
                check("sb_instr", 32'(o_instr), 32'(e.instr));
                check("sb_opcode", 32'(o_opcode), 32'(e.instr[15:12]));
            end
        end
        last_valid = o_valid;
    endtask

    // Drive control inputs and the memory model for the coming rising edge
    task automatic drive(input logic stall, input logic redir, input logic [7:0] rpc);
        logic hs;
        i_stall       = stall;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        last_stall    = stall;
        i_imem_gnt    = gnt_en;
        if (mem_pending && mem_cnt == 1) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_rd;
            mem_pending   = 1'b0;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = 16'hDEAD;
            if (mem_pending) mem_cnt--;
        end
        hs = o_imem_req && gnt_en;
        if (redir) sbq.delete();
        else if (hs) sbq.push_back('{pc: o_imem_addr, instr: mem_data(o_imem_addr)});
        if (hs) begin
            mem_pending = 1'b1;
            mem_cnt     = mem_lat;
            mem_rd      = mem_data(o_imem_addr);
        end
    endtask

    // mode 0: request, 1: valid, 2: valid with request; ends positioned at a sample
    task automatic run_until(input int mode, input string name);
        logic c;
        for (int n = 0; n <= 20; n++) begin
            sample();
            case (mode)
                0:       c = o_imem_req;
                1:       c = o_valid;
                default: c = o_valid && o_imem_req;
            endcase
            if (c) return;
            if (n == 20) begin
                checks++;
                errors++;
                $display("FAIL %s: condition not reached within 20 cycles", name);
                return;
            end
            drive(1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held_pc;
        logic [7:0] nxt;

        vecs[0] = '{8'h40, 16'hFC40, 8'h41};
        vecs[1] = '{8'hFF, 16'h0CFF, 8'h00};
        vecs[2] = '{8'h13, 16'hCC13, 8'h14};
        vecs[3] = '{8'h7E, 16'h1C7E, 8'h7F};

        i_reset = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 8'h00;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 16'h0000;
        fixed_mode = 1'b1; gnt_en = 1'b1; mem_lat = 1; mem_pending = 1'b0; mem_cnt = 0;
        mem_rd = 16'h0000; last_valid = 1'b0; last_stall = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_pc", 32'(o_pc), 32'd0);
        check("rst_instr", 32'(o_instr), 32'd0);
        check("rst_addr", 32'(o_imem_addr), 32'd0);

        // First fetch with fixed memory data
        i_reset = 1'b0;
        check("first_req", 32'({o_imem_req, o_imem_addr}), 32'h100);
        drive(1'b0, 1'b0, 8'h00);
        sample();
        drive(1'b0, 1'b0, 8'h00);
        sample();
        check("first_valid", 32'(o_valid), 32'd1);
        check("first_pc", 32'(o_pc), 32'h00);
        check("first_instr", 32'(o_instr), 32'h1234);
        check("first_opcode", 32'(o_opcode), 32'h1);
        check("second_req", 32'({o_imem_req, o_imem_addr}), 32'h101);
        drive(1'b0, 1'b0, 8'h00);
        fixed_mode = 1'b0;

        // Stall for four cycles while a response lands in the skid buffer
        run_until(2, "stall_setup");
        held_pc = o_pc;
        nxt     = o_imem_addr;
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            sample();
            check("stall_hold_pc", 32'({o_valid, o_pc}), 32'({1'b1, held_pc}));
            check("stall_no_req", 32'(o_imem_req), 32'd0);
            drive((i < 3) ? 1'b1 : 1'b0, 1'b0, 8'h00);
        end
        sample();
        check("skid_out_pc", 32'({o_valid, o_pc}), 32'({1'b1, nxt}));
        check("skid_resume_req", 32'({o_imem_req, o_imem_addr}), 32'({1'b1, nxt + 8'd1}));
        drive(1'b0, 1'b0, 8'h00);

        // Redirect table: redirect in S_WAIT with a 2-cycle memory so the old response is killed
        mem_lat = 2;
        for (int v = 0; v < 4; v++) begin
            run_until(0, "vec_req");
            drive(1'b0, 1'b0, 8'h00);
            sample();
            check("vec_wait_noreq", 32'(o_imem_req), 32'd0);
            drive(1'b0, 1'b1, vecs[v].tgt);
            sample();
            check("vec_redir_valid", 32'(o_valid), 32'd0);
            drive(1'b0, 1'b0, 8'h00);
            sample();
            check("vec_target_req", 32'({o_imem_req, o_imem_addr}), 32'({1'b1, vecs[v].tgt}));
            drive(1'b0, 1'b0, 8'h00);
            run_until(1, "vec_valid");
            check("vec_pc", 32'(o_pc), 32'(vecs[v].tgt));
            check("vec_instr", 32'(o_instr), 32'(vecs[v].exp_instr));
            check("vec_opcode", 32'(o_opcode), 32'(vecs[v].exp_instr[15:12]));
            check("vec_next_req", 32'({o_imem_req, o_imem_addr}), 32'({1'b1, vecs[v].exp_next}));
            drive(1'b0, 1'b0, 8'h00);
        end

        // Redirect together with stall while IF/ID is valid and the skid buffer is full
        mem_lat = 1;
        run_until(2, "rs_setup");
        drive(1'b1, 1'b0, 8'h00);
        sample();
        drive(1'b1, 1'b0, 8'h00);
        sample();
        check("rs_hold_noreq", 32'({o_valid, o_imem_req}), 32'h2);
        gnt_en = 1'b0;
        drive(1'b1, 1'b1, 8'h80);
        sample();
        check("rs_valid", 32'(o_valid), 32'd0);
        check("rs_req", 32'({o_imem_req, o_imem_addr}), 32'h180);
        gnt_en = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        run_until(1, "rs_valid_wait");
        check("rs_pc", 32'(o_pc), 32'h80);
        check("rs_instr", 32'(o_instr), 32'hFC80);
        drive(1'b0, 1'b0, 8'h00);

        // Asynchronous reset while waiting on a response
        run_until(2, "rst_setup");
        drive(1'b1, 1'b0, 8'h00);
        sample();
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_pc", 32'(o_pc), 32'd0);
        check("arst_instr", 32'(o_instr), 32'd0);
        check("arst_addr", 32'({o_imem_req, o_imem_addr}), 32'h100);
        sbq.delete();
        mem_pending = 1'b0;
        i_imem_rvalid = 1'b0;
        i_stall = 1'b0;
        last_valid = 1'b0;
        last_stall = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        check("arst_first_req", 32'({o_imem_req, o_imem_addr}), 32'h100);
`ifdef FETCH_PERF_CNT_EN
        check("arst_fetch_cnt", 32'(o_fetch_cnt), 32'd0);
        check("arst_bubble_cnt", 32'(o_bubble_cnt), 32'd0);
`endif
        drive(1'b0, 1'b0, 8'h00);
        run_until(1, "arst_valid_wait");
        check("arst_fetch_pc", 32'(o_pc), 32'h00);
        check("arst_fetch_instr", 32'(o_instr), 32'hFC00);
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            sample();
            drive(1'b0, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
